// File: rtl/m_lsu_pkg.sv
// Shared constants, state codes and bus payload type for the m_lsu load/store unit.
package m_lsu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned BEW      = XLEN / 8;
    localparam int unsigned TYPEW    = 3;
    localparam int unsigned WAITW    = 8;
    localparam int unsigned WAIT_MAX = 255;

    localparam logic [TYPEW-1:0] DM_W  = 3'd0;
    localparam logic [TYPEW-1:0] DM_H  = 3'd1;
    localparam logic [TYPEW-1:0] DM_HU = 3'd2;
    localparam logic [TYPEW-1:0] DM_B  = 3'd3;
    localparam logic [TYPEW-1:0] DM_BU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic            we;
        logic [BEW-1:0]  be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } bus_cmd_t;

    function automatic logic f_type_valid(input logic [TYPEW-1:0] t);
        return (t <= DM_BU);
    endfunction

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    function automatic logic f_misaligned(input logic [TYPEW-1:0] t, input logic [1:0] a);
        logic m;
        m = 1'b0;
        if (t == DM_W) begin
            m = (a != 2'b00);
        end else if ((t == DM_H) || (t == DM_HU)) begin
            m = a[0];
        end
        return m;
    endfunction

endpackage

// File: rtl/m_lsu_align.sv
// Byte-lane logic: byte enables and store replication on request, load extraction/extension on response.
module m_lsu_align
    import m_lsu_pkg::*;
(
    input  logic [TYPEW-1:0] i_req_type,
    input  logic [1:0]       i_req_addr_lo,
    input  logic [XLEN-1:0]  i_req_wdata,
    output logic [BEW-1:0]   o_be_c,
    output logic [XLEN-1:0]  o_wdata_c,
    input  logic [TYPEW-1:0] i_rsp_type,
    input  logic [1:0]       i_rsp_addr_lo,
    input  logic [XLEN-1:0]  i_rsp_rdata,
    output logic [XLEN-1:0]  o_rdata_c
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Store lanes; unsigned store types behave as their signed counterparts.
    always_comb begin
        o_be_c    = '0;
        o_wdata_c = i_req_wdata;
        case (i_req_type)
            DM_W: begin
                o_be_c = 4'b1111;
            end
            DM_H, DM_HU: begin
                o_be_c    = i_req_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_c = {2{i_req_wdata[15:0]}};
            end
            DM_B, DM_BU: begin
                o_be_c    = 4'b0001 << i_req_addr_lo;
                o_wdata_c = {4{i_req_wdata[7:0]}};
            end
            default: begin
                o_be_c    = '0;
                o_wdata_c = '0;
            end
        endcase
    end

    assign w_half = i_rsp_addr_lo[1] ? i_rsp_rdata[31:16] : i_rsp_rdata[15:0];

    always_comb begin
        w_byte = i_rsp_rdata[7:0];
        case (i_rsp_addr_lo)
            2'd0:    w_byte = i_rsp_rdata[7:0];
            2'd1:    w_byte = i_rsp_rdata[15:8];
            2'd2:    w_byte = i_rsp_rdata[23:16];
            default: w_byte = i_rsp_rdata[31:24];
        endcase
    end

    always_comb begin
        o_rdata_c = '0;
        case (i_rsp_type)
            DM_W:    o_rdata_c = i_rsp_rdata;
            DM_H:    o_rdata_c = {{16{w_half[15]}}, w_half};
            DM_HU:   o_rdata_c = {16'h0000, w_half};
            DM_B:    o_rdata_c = {{24{w_byte[7]}}, w_byte};
            DM_BU:   o_rdata_c = {24'h000000, w_byte};
            default: o_rdata_c = '0;
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// Single-outstanding load/store unit with wait-limited memory bus handshake.
// Define MISALIGN_EXC_EN to raise exc_adel/exc_ades on misaligned w/h accesses instead of truncating.
module m_lsu
    import m_lsu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [TYPEW-1:0] req_type,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             bus_req,
    output logic             bus_we,
    output logic [BEW-1:0]   bus_be,
    output logic [XLEN-1:0]  bus_addr,
    output logic [XLEN-1:0]  bus_wdata,
    input  logic             bus_ack,
    input  logic [XLEN-1:0]  bus_rdata,
    output logic             exc_adel,
    output logic             exc_ades,
    output logic             exc_bus
);

    lsu_state_e       r_state;
    lsu_state_e       w_state_nxt;
    bus_cmd_t         r_cmd;
    bus_cmd_t         w_cmd_nxt;
    logic             r_bus_req,    w_bus_req_nxt;
    logic [TYPEW-1:0] r_type,       w_type_nxt;
    logic [1:0]       r_addr_lo,    w_addr_lo_nxt;
    logic [WAITW-1:0] r_wait,       w_wait_nxt;
    logic             r_req_ready;
    logic             r_resp_valid, w_resp_valid_nxt;
    logic [XLEN-1:0]  r_resp_rdata, w_resp_rdata_nxt;
    logic             r_exc_adel,   w_exc_adel_nxt;
    logic             r_exc_ades,   w_exc_ades_nxt;
    logic             r_exc_bus,    w_exc_bus_nxt;

    logic             w_accept;
    logic             w_misalign;
    logic             w_skip;
    logic             w_ack;
    logic             w_timeout;
    logic [BEW-1:0]   w_be_c;
    logic [XLEN-1:0]  w_wdata_c;
    logic [XLEN-1:0]  w_rdata_c;

    m_lsu_align u_align (
        .i_req_type    (req_type),
        .i_req_addr_lo (req_addr[1:0]),
        .i_req_wdata   (req_wdata),
        .o_be_c        (w_be_c),
        .o_wdata_c     (w_wdata_c),
        .i_rsp_type    (r_type),
        .i_rsp_addr_lo (r_addr_lo),
        .i_rsp_rdata   (bus_rdata),
        .o_rdata_c     (w_rdata_c)
    );

`ifdef MISALIGN_EXC_EN
    assign w_misalign = f_misaligned(req_type, req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept  = req_valid && r_req_ready;
    assign w_skip    = !f_type_valid(req_type) || w_misalign;
    assign w_ack     = (r_state == ST_BUS) && bus_ack;
    // Timeout fires on the edge closing the WAIT_MAX-th BUS cycle; an ack on that edge still wins.
    assign w_timeout = (r_state == ST_BUS) && !bus_ack && (r_wait == WAITW'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_skip ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (w_ack || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_nxt        = r_cmd;
        w_bus_req_nxt    = 1'b0;
        w_type_nxt       = r_type;
        w_addr_lo_nxt    = r_addr_lo;
        w_wait_nxt       = r_wait;
        w_resp_valid_nxt = 1'b0;
        w_resp_rdata_nxt = r_resp_rdata;
        w_exc_adel_nxt   = 1'b0;
        w_exc_ades_nxt   = 1'b0;
        w_exc_bus_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_skip) begin
                    w_cmd_nxt.we    = req_we;
                    w_cmd_nxt.be    = w_be_c;
                    w_cmd_nxt.addr  = {req_addr[XLEN-1:2], 2'b00};
                    w_cmd_nxt.wdata = w_wdata_c;
                    w_bus_req_nxt   = 1'b1;
                    w_type_nxt      = req_type;
                    w_addr_lo_nxt   = req_addr[1:0];
                    w_wait_nxt      = '0;
                end else if (w_accept) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = '0;
                    w_exc_adel_nxt   = w_misalign && !req_we;
                    w_exc_ades_nxt   = w_misalign && req_we;
                end
            end
            ST_BUS: begin
                if (w_ack) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = r_cmd.we ? '0 : w_rdata_c;
                end else if (w_timeout) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = '0;
                    w_exc_bus_nxt    = 1'b1;
                end else begin
                    w_bus_req_nxt = 1'b1;
                    w_wait_nxt    = r_wait + WAITW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd        <= '0;
            r_bus_req    <= 1'b0;
            r_type       <= '0;
            r_addr_lo    <= '0;
            r_wait       <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_exc_adel   <= 1'b0;
            r_exc_ades   <= 1'b0;
            r_exc_bus    <= 1'b0;
        end else begin
            r_cmd        <= w_cmd_nxt;
            r_bus_req    <= w_bus_req_nxt;
            r_type       <= w_type_nxt;
            r_addr_lo    <= w_addr_lo_nxt;
            r_wait       <= w_wait_nxt;
            r_req_ready  <= (w_state_nxt == ST_IDLE);
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_exc_adel   <= w_exc_adel_nxt;
            r_exc_ades   <= w_exc_ades_nxt;
            r_exc_bus    <= w_exc_bus_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign bus_req    = r_bus_req;
    assign bus_we     = r_cmd.we;
    assign bus_be     = r_cmd.be;
    assign bus_addr   = r_cmd.addr;
    assign bus_wdata  = r_cmd.wdata;
    assign exc_adel   = r_exc_adel;
    assign exc_ades   = r_exc_ades;
    assign exc_bus    = r_exc_bus;

endmodule

// File: doc/m_lsu.md
M_LSU -- requirements
Module: m_lsu

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on posedge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port: req_valid  in  1  pipeline requests one load/store.
REQ-004 SHALL have port: req_we  in  1  1 = store, 0 = load.
REQ-005 SHALL have port: req_type  in  3  DM_w / DM_h / DM_hu / DM_b / DM_bu access type.
REQ-006 SHALL have ports: req_addr  in  32  byte address; req_wdata  in  32  store data (low bits used for h/b).
REQ-007 SHALL have port: req_ready  out  1  high only in IDLE; pipeline stalls while low.
REQ-008 SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  32  extended load data.
REQ-009 SHALL have ports: bus_req  out  1; bus_we  out  1; bus_be  out  4; bus_addr  out  32 (word-aligned); bus_wdata  out  32.
REQ-010 SHALL have ports: bus_ack  in  1  memory completion; bus_rdata  in  32  full word read.
REQ-011 SHALL have ports: exc_adel  out  1; exc_ades  out  1; exc_bus  out  1  (one-cycle pulses coincident with resp_valid).

Function
REQ-012 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; handshake accepted when req_valid && req_ready.
REQ-013 SHALL, on accept, register bus_addr = {req_addr[31:2],2'b00}, bus_we, bus_be and lane-replicated bus_wdata, and assert bus_req the next cycle.
REQ-014 SHALL hold all bus_* outputs stable while bus_req=1 and bus_ack=0.
REQ-015 SHALL generate bus_be: w -> 4'b1111; h/hu -> 4'b0011 << (2*addr[1]); b/bu -> 4'b0001 << addr[1:0].
REQ-016 SHALL replicate store data: h -> {2{wdata[15:0]}}, b -> {4{wdata[7:0]}}; store with hu/bu SHALL behave as h/b.
REQ-017 SHALL, on bus_ack in BUS, drop bus_req that edge, capture load result, go to RESP; resp_valid=1 for exactly the RESP cycle.
REQ-018 SHALL extend load data: h sign-extends halfword addr[1]; hu zero-extends; b sign-extends byte addr[1:0]; bu zero-extends; w raw.
REQ-019 SHALL set resp_rdata = 0 for stores and hold resp_rdata until the next response.
REQ-020 SHALL complete req_type values 5-7 with no bus transaction: resp_valid next cycle, rdata 0, no exception.
REQ-021 SHALL count BUS cycles in an 8-bit wait counter; at 255 cycles without ack: drop bus_req, pulse exc_bus with resp_valid, rdata 0.
REQ-022 SHALL have minimum latency 2 cycles accept->resp_valid (ack in first BUS cycle); bus_ack outside BUS SHALL be ignored.

Reset
REQ-023 SHALL, on reset low, immediately force state IDLE, bus_req=0, resp_valid=0, all exc_*=0, resp_rdata=0, bus_addr/be/wdata=0, bus_we=0, counter=0.
REQ-024 SHALL abandon an in-flight transaction on reset with no response; req_ready=1 on the first edge after release.

Configuration
REQ-025 SHALL use macro MISALIGN_EXC_EN.
REQ-026 With MISALIGN_EXC_EN defined: w with addr[1:0]!=0 or h/hu with addr[0]=1 SHALL skip bus, go directly to RESP, pulse exc_adel (load) or exc_ades (store), rdata 0.
REQ-027 Without MISALIGN_EXC_EN: exc_adel/exc_ades SHALL be tied 0; misaligned addresses SHALL be truncated (w ignores addr[1:0], h ignores addr[0]).

Structure
REQ-028 SHALL take DM_w=0, DM_h=1, DM_hu=2, DM_b=3, DM_bu=4 and FSM state codes from shared const.v.
REQ-029 SHALL place lane select/extension in one combinational sub-module m_lsu_align (bus_be, wdata replication, rdata extension).

Verification
REQ-030 lw addr 0x0000_0010, bus_rdata 0xDEADBEEF, ack after 3 cycles -> bus_be 1111, bus_addr 0x10, resp_rdata 0xDEADBEEF, 5 cycles accept->resp.
REQ-031 lb addr 0x13, bus_rdata 0x80FF_0000 -> be 1000, resp_rdata 0xFFFF_FF80; lbu same -> 0x0000_0080.
REQ-032 sh addr 0x22, wdata 0x1234_ABCD -> bus_be 1100, bus_wdata 0xABCD_ABCD, bus_we=1, resp_rdata 0.
REQ-033 lw addr 0x21 with MISALIGN_EXC_EN -> no bus_req, exc_adel+resp_valid next cycle; without -> bus_addr 0x20, be 1111.
REQ-034 bus_ack never asserted -> bus_req dropped after 255 BUS cycles, exc_bus pulse, req_ready returns 1.
REQ-035 reset low during BUS -> bus_req 0 same cycle, no resp_valid; new sb after release completes normally.
